// File: rtl/seg_scan_controller.sv
// Four-digit 7-segment scan controller: one shared BCD decoder, blank gap between digits,
// once-per-frame input snapshot. Optional leading-zero suppression via LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
  parameter int BLANK_CYCLES = 2,
  parameter int DRIVE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  localparam int MAX_CYCLES = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   sh_digits_q, sh_digits_d;
  logic [3:0]    sh_en_q, sh_en_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic [3:0]    mask_d;
  logic          wrap;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          dp_q, dp_d;
  logic          fs_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] mask_q;

  // Blank enabled zero digits from the top until a nonzero or dp-marked enabled digit.
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] d, input logic [3:0] en,
                                                input logic [3:0] pt);
    logic [3:0] m;
    logic       suppress;
    m = 4'b0000;
    suppress = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (en[i]) begin
        if (suppress && (d[4*i +: 4] == 4'd0) && !pt[i]) m[i] = 1'b1;
        else suppress = 1'b0;
      end
    end
    return m;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + CW'(1);
    sh_digits_d = sh_digits_q;
    sh_en_d     = sh_en_q;
    sh_dp_d     = sh_dp_q;
    wrap        = 1'b0;
    case (state_q)
      S_BLANK: begin
        if ((BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST)) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
          wrap    = (idx_q == 2'd3);
        end
      end
      default: state_d = S_BLANK;
    endcase

    if (wrap) begin
      sh_digits_d = digits;
      sh_en_d     = digit_en;
      sh_dp_d     = dp_in;
    end

`ifdef LEADING_ZERO_BLANK_EN
    mask_d = wrap ? lead_zero_mask(digits, digit_en, dp_in) : mask_q;
`else
    mask_d = 4'b0000;
`endif

    // Outputs are computed from next-state values so they register on the same edge.
    an_d  = 4'b1111;
    bcd_d = 4'hF;
    dp_d  = 1'b1;
    if ((state_d == S_DRIVE) && !mask_d[idx_d]) begin
      bcd_d = sh_digits_d[{idx_d, 2'b00} +: 4];
      if (sh_en_d[idx_d]) begin
        an_d[idx_d] = 1'b0;
        dp_d        = ~sh_dp_d[idx_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BLANK;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      sh_digits_q <= 16'h0000;
      sh_en_q     <= 4'h0;
      sh_dp_q     <= 4'h0;
      an_q        <= 4'b1111;
      bcd_q       <= 4'hF;
      dp_q        <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      sh_digits_q <= sh_digits_d;
      sh_en_q     <= sh_en_d;
      sh_dp_q     <= sh_dp_d;
      an_q        <= an_d;
      bcd_q       <= bcd_d;
      dp_q        <= dp_d;
      fs_q        <= wrap;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= 4'h0;
    else        mask_q <= mask_d;
  end
`endif

  assign an          = an_q;
  assign bcd_out     = bcd_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: a blank-gap build (BLANK=2) and a no-gap build (BLANK=0)
// checked every cycle against a position-based model of the scan.
module tb_seg_scan_controller;

  localparam int BC = 2;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  digit_en, dp_in;
  logic [3:0]  bcd_out, an, bcd_out0, an0;
  logic        dp, frame_start, dp0, frame_start0;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: position since reset and the frame's captured inputs
  int          pos, pos0;
  logic [15:0] m_d, m0_d;
  logic [3:0]  m_en, m_dp, m0_en, m0_dp;

  always #5 clk = ~clk;

  seg_scan_controller #(.BLANK_CYCLES(BC), .DRIVE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .digit_en(digit_en), .dp_in(dp_in),
    .bcd_out(bcd_out), .an(an), .dp(dp), .frame_start(frame_start)
  );

  seg_scan_controller #(.BLANK_CYCLES(0), .DRIVE_CYCLES(DC)) dut0 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .digit_en(digit_en), .dp_in(dp_in),
    .bcd_out(bcd_out0), .an(an0), .dp(dp0), .frame_start(frame_start0)
  );

  function automatic bit is_frame_edge(int n, int b);
    int eff;
    eff = (b == 0) ? n - 1 : n;
    return (n >= 1) && (eff > 0) && ((eff % (4 * (b + DC))) == 0);
  endfunction

  function automatic logic [3:0] lz_mask(logic [15:0] d, logic [3:0] en, logic [3:0] pt);
    logic [3:0] m;
    bit lead;
    m = 4'b0000;
    lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (en[i] && ((d[4*i +: 4] != 4'd0) || pt[i])) lead = 1'b0;
      if (lead && en[i]) m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  // expected {an, bcd_out, dp, frame_start} at position n
  function automatic logic [9:0] exp_out(int n, int b, logic [15:0] d, logic [3:0] en,
                                         logic [3:0] pt);
    logic [3:0] e_an, e_bcd, m;
    logic e_dp, e_fs;
    int eff, slot_len, o, slot, w;
    e_an = 4'b1111; e_bcd = 4'hF; e_dp = 1'b1; e_fs = 1'b0;
    if (!(b == 0 && n == 0)) begin
      slot_len = b + DC;
      eff  = (b == 0) ? n - 1 : n;
      o    = eff % (4 * slot_len);
      slot = o / slot_len;
      w    = o % slot_len;
      e_fs = (eff > 0) && (o == 0);
      m    = lz_mask(d, en, pt);
      if (w >= b && !m[slot]) begin
        e_bcd = d[4*slot +: 4];
        if (en[slot]) begin
          e_an[slot] = 1'b0;
          e_dp = ~pt[slot];
        end
      end
    end
    return {e_an, e_bcd, e_dp, e_fs};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 0; pos0 <= 0;
      m_d <= '0; m_en <= '0; m_dp <= '0;
      m0_d <= '0; m0_en <= '0; m0_dp <= '0;
    end else begin
      pos  <= pos + 1;
      pos0 <= pos0 + 1;
      if (is_frame_edge(pos + 1, BC)) begin
        m_d <= digits; m_en <= digit_en; m_dp <= dp_in;
      end
      if (is_frame_edge(pos0 + 1, 0)) begin
        m0_d <= digits; m0_en <= digit_en; m0_dp <= dp_in;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] got, exp;
    rst_n = 1'b0; digits = 16'h0000; digit_en = 4'h0; dp_in = 4'h0;
    step(); step();
    n_tests++;
    if ({an, bcd_out, dp, frame_start} !== 10'b1111_1111_1_0) begin
      n_fail++; $display("FAIL reset_main got=%b exp=%b", {an, bcd_out, dp, frame_start}, 10'b1111111110);
    end
    n_tests++;
    if ({an0, bcd_out0, dp0, frame_start0} !== 10'b1111_1111_1_0) begin
      n_fail++; $display("FAIL reset_nogap got=%b exp=%b", {an0, bcd_out0, dp0, frame_start0}, 10'b1111111110);
    end
    digits = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 4 * (BC + DC); i++) begin
      step();
      n_tests++;
      if (an !== 4'b1111) begin
        n_fail++; $display("FAIL dark_frame pos=%0d an=%b exp=1111", pos, an);
      end
      got = {an, bcd_out, dp, frame_start};
      exp = exp_out(pos, BC, m_d, m_en, m_dp);
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL dark_model pos=%0d got=%b exp=%b", pos, got, exp);
      end
    end
    n_tests++;
    if (frame_start !== 1'b1) begin
      n_fail++; $display("FAIL first_frame_start got=%b exp=1", frame_start);
    end
  endtask

  task automatic test_scan(string name, int cycles);
    logic [9:0] got, exp;
    for (int i = 0; i < cycles; i++) begin
      step();
      got = {an, bcd_out, dp, frame_start};
      exp = exp_out(pos, BC, m_d, m_en, m_dp);
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s pos=%0d got=%b exp=%b", name, pos, got, exp);
      end
      got = {an0, bcd_out0, dp0, frame_start0};
      exp = exp_out(pos0, 0, m0_d, m0_en, m0_dp);
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s_nogap pos=%0d got=%b exp=%b", name, pos0, got, exp);
      end
    end
  endtask

  task automatic test_mid_update();
    int guard;
    logic [9:0] got, exp;
    guard = 0;
    while (((pos % 24) / 6) != 1 && guard < 40) begin
      step(); guard++;
    end
    n_tests++;
    if (guard >= 40) begin
      n_fail++; $display("FAIL mid_update_wait got=timeout exp=digit1");
    end
    digits = 16'h5678;
    for (int i = 0; i < 48; i++) begin
      step();
      got = {an, bcd_out, dp, frame_start};
      exp = exp_out(pos, BC, m_d, m_en, m_dp);
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL mid_update pos=%0d got=%b exp=%b", pos, got, exp);
      end
    end
  endtask

  task automatic test_blank0_overlap();
    logic [3:0] prev;
    int direct;
    direct = 0;
    digits = 16'h4321; digit_en = 4'hF; dp_in = 4'h0;
    for (int i = 0; i < 40; i++) begin
      prev = an0;
      step();
      n_tests++;
      if ($countones(~an0) > 1) begin
        n_fail++; $display("FAIL nogap_onehot an=%b exp=at_most_one_low", an0);
      end
      if (prev == 4'b1110 && an0 == 4'b1101) direct++;
    end
    n_tests++;
    if (direct < 1) begin
      n_fail++; $display("FAIL nogap_direct got=%0d transitions exp=>=1", direct);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while ((pos % 24) != 14 && guard < 40) begin
      step(); guard++;
    end
    n_tests++;
    if (guard >= 40) begin
      n_fail++; $display("FAIL reset_mid_wait got=timeout exp=digit2_drive");
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({an, bcd_out, dp, frame_start} !== 10'b1111_1111_1_0) begin
      n_fail++; $display("FAIL reset_async got=%b exp=%b", {an, bcd_out, dp, frame_start}, 10'b1111111110);
    end
    n_tests++;
    if ({an0, bcd_out0, dp0, frame_start0} !== 10'b1111_1111_1_0) begin
      n_fail++; $display("FAIL reset_async_nogap got=%b exp=%b", {an0, bcd_out0, dp0, frame_start0}, 10'b1111111110);
    end
    @(negedge clk);
    step();
    rst_n = 1'b1;
    test_scan("after_reset", 60);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        digits = 16'($urandom);
        digit_en = 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
      end
      test_scan("random", $urandom_range(3, 12));
    end
  endtask

  initial begin
    test_reset();
    test_scan("scan", 48);
    test_mid_update();
    digit_en = 4'b0101; dp_in = 4'b0100;
    test_scan("enable_dp", 48);
    test_blank0_overlap();
    test_reset_mid();
    digits = 16'h0070; digit_en = 4'hF; dp_in = 4'h0;
    test_scan("lead_zero", 48);
    digits = 16'h0000;
    test_scan("all_zero", 48);
    digits = 16'h0005; dp_in = 4'b0100;
    test_scan("zero_dp", 48);
    digits = 16'h00AF; dp_in = 4'h0;
    test_scan("invalid_codes", 48);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
